// File: rtl/sobel_gradient.sv
// Three-stage pipelined Sobel edge magnitude (|Gx|+|Gy|, saturated, optional threshold)
// with a global stall, frame pixel counting, last-pixel flag and frame-done pulse.
module sobel_gradient #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  win_valid,
    output logic                  win_ready,
    input  logic [9*DATA_W-1:0]   window_in,
    input  logic                  bin_en,
    input  logic [DATA_W-1:0]     thresh,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_W-1:0]     pix_out,
    output logic                  pix_last,
    output logic                  frame_done
);

    localparam int GW    = DATA_W + 3;
    localparam int AW    = DATA_W + 2;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0]     LAST_IDX = CW'(NPIX - 1);
    localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};

    function automatic logic [GW-1:0] px(input logic [9*DATA_W-1:0] w, input int k);
        return GW'(w[k*DATA_W +: DATA_W]);
    endfunction

    // Magnitude of a two's-complement gradient; max 4*pixel_max fits in AW bits.
    function automatic logic [AW-1:0] abs_val(input logic signed [GW-1:0] v);
        logic [GW-1:0] a;
        a = v[GW-1] ? GW'(-v) : GW'(v);
        return a[AW-1:0];
    endfunction

    logic                     advance_s;
    logic                     s2_enter_s;
    logic                     handshake_s;
    logic [GW-1:0]            gx_s;
    logic [GW-1:0]            gy_s;
    logic [GW-1:0]            mag_s;
    logic [DATA_W-1:0]        sat_s;
    logic [DATA_W-1:0]        res_s;

    logic                     s1_valid_r;
    logic signed [GW-1:0]     gx_r;
    logic signed [GW-1:0]     gy_r;
    logic                     s1_bin_r;
    logic [DATA_W-1:0]        s1_thresh_r;
    logic                     s2_valid_r;
    logic [AW-1:0]            ax_r;
    logic [AW-1:0]            ay_r;
    logic                     s2_bin_r;
    logic [DATA_W-1:0]        s2_thresh_r;
    logic [CW-1:0]            in_cnt_r;
    logic [CW-1:0]            out_cnt_r;

    assign advance_s   = !pix_valid || pix_ready;
    assign win_ready   = advance_s;
    assign s2_enter_s  = advance_s && s2_valid_r;
    assign handshake_s = pix_valid && pix_ready;

    // Gradient arithmetic for the incoming window and the final result for the S2 pixel.
    always_comb begin
        gx_s  = (px(window_in, 2) + (px(window_in, 5) << 1'b1) + px(window_in, 8))
              - (px(window_in, 0) + (px(window_in, 3) << 1'b1) + px(window_in, 6));
        gy_s  = (px(window_in, 6) + (px(window_in, 7) << 1'b1) + px(window_in, 8))
              - (px(window_in, 0) + (px(window_in, 1) << 1'b1) + px(window_in, 2));
        mag_s = GW'(ax_r) + GW'(ay_r);
        if (mag_s > GW'(PIX_MAX)) begin
            sat_s = PIX_MAX;
        end else begin
            sat_s = mag_s[DATA_W-1:0];
        end
        if (s2_bin_r) begin
            res_s = (sat_s >= s2_thresh_r) ? PIX_MAX : {DATA_W{1'b0}};
        end else begin
            res_s = sat_s;
        end
    end

    // Pipeline stages; everything holds while the output is stalled.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            s1_valid_r  <= 1'b0;
            gx_r        <= '0;
            gy_r        <= '0;
            s1_bin_r    <= 1'b0;
            s1_thresh_r <= '0;
            s2_valid_r  <= 1'b0;
            ax_r        <= '0;
            ay_r        <= '0;
            s2_bin_r    <= 1'b0;
            s2_thresh_r <= '0;
            pix_valid   <= 1'b0;
            pix_out     <= '0;
            pix_last    <= 1'b0;
        end else if (advance_s) begin
            s1_valid_r  <= win_valid;
            gx_r        <= gx_s;
            gy_r        <= gy_s;
            s1_bin_r    <= bin_en;
            s1_thresh_r <= thresh;
            s2_valid_r  <= s1_valid_r;
            ax_r        <= abs_val(gx_r);
            ay_r        <= abs_val(gy_r);
            s2_bin_r    <= s1_bin_r;
            s2_thresh_r <= s1_thresh_r;
            pix_valid   <= s2_valid_r;
            pix_out     <= res_s;
            pix_last    <= (in_cnt_r == LAST_IDX);
        end
    end

    // Entry/output pixel counters and the frame-done pulse; start overrides a handshake.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            in_cnt_r   <= '0;
            out_cnt_r  <= '0;
            frame_done <= 1'b0;
        end else if (start) begin
            in_cnt_r   <= '0;
            out_cnt_r  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= handshake_s && pix_last;
            if (s2_enter_s) begin
                in_cnt_r <= (in_cnt_r == LAST_IDX) ? '0 : in_cnt_r + CW'(1);
            end
            if (handshake_s) begin
                out_cnt_r <= (out_cnt_r == LAST_IDX) ? '0 : out_cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient.sv
// Scoreboard bench for sobel_gradient with a 4x2 frame: reference model on accept,
// in-order compare on output, stall/backpressure, frame flags, start and async reset.
module tb_sobel_gradient;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] window_in;
    logic        bin_en;
    logic [7:0]  thresh;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_out;
    logic        pix_last;
    logic        frame_done;

    always #5 clk = ~clk;

    sobel_gradient #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .win_valid(win_valid), .win_ready(win_ready), .window_in(window_in),
        .bin_en(bin_en), .thresh(thresh),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_out(pix_out),
        .pix_last(pix_last), .frame_done(frame_done)
    );

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   exp_idx      = 0;
    logic fd_pending   = 1'b0;
    logic stream_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3,
                                       input logic [7:0] b4, input logic [7:0] b5,
                                       input logic [7:0] b6, input logic [7:0] b7,
                                       input logic [7:0] b8);
        return {b8, b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] ref_pix(input logic [71:0] w, input logic b, input logic [7:0] th);
        int p[9];
        int gx, gy, mag, s;
        for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
        gx  = p[2] + 2*p[5] + p[8] - p[0] - 2*p[3] - p[6];
        gy  = p[6] + 2*p[7] + p[8] - p[0] - 2*p[1] - p[2];
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        s   = (mag > 255) ? 255 : mag;
        if (b) s = (s >= int'(th)) ? 255 : 0;
        return 8'(s);
    endfunction

    // Scoreboard: push on accept, compare head every valid cycle, pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        logic fd_next;
        if (n_rst) begin
            sb.delete();
            exp_idx    = 0;
            fd_pending = 1'b0;
        end else begin
            fd_next = 1'b0;
            check("frame_done", 32'(frame_done), 32'(fd_pending));
            check("win_ready", 32'(win_ready), 32'(!pix_valid || pix_ready));
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pix", 32'(pix_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check("pix_out", 32'(pix_out), 32'(e.pix));
                    check("pix_last", 32'(pix_last), 32'(e.last));
                    if (pix_ready) begin
                        void'(sb.pop_front());
                        fd_next = e.last;
                    end
                end
            end
            if (start) begin
                fd_next = 1'b0;
                exp_idx = 0;
            end
            fd_pending = fd_next;
            if (win_valid && win_ready) begin
                e.pix  = ref_pix(window_in, bin_en, thresh);
                e.last = (exp_idx == 7);
                sb.push_back(e);
                exp_idx = (exp_idx == 7) ? 0 : exp_idx + 1;
            end
        end
    end

    task automatic send(input logic [71:0] w, input logic b, input logic [7:0] th);
        int n;
        win_valid = 1'b1;
        window_in = w;
        bin_en    = b;
        thresh    = th;
        n = 0;
        @(negedge clk);
        while (!win_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!win_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        logic [71:0] w;
        w = {8'($urandom), 32'($urandom), 32'($urandom)};
        send(w, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic drain();
        int n;
        win_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic latency_test(input string tag);
        int n;
        win_valid = 1'b1;
        window_in = pk(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        bin_en    = 1'b0;
        thresh    = 8'd0;
        @(posedge clk);
        #1;
        win_valid = 1'b0;
        n = 1;
        while (!pix_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n), 32'd3);
        check("p2_value", 32'(pix_out), 32'd20);
    endtask

    initial begin
        n_rst = 1'b1; start = 1'b0; win_valid = 1'b0; window_in = '0;
        bin_en = 1'b0; thresh = 8'd0; pix_ready = 1'b1; stream_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_out", 32'(pix_out), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_win_ready", 32'(win_ready), 32'd1);
        n_rst = 1'b0;
        @(posedge clk);
        #1;

        latency_test("latency");
        drain();

        // Directed windows, including the threshold boundary (>=).
        send(pk(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128), 1'b0, 8'd0);
        send(pk(8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255), 1'b0, 8'd0);
        send(pk(8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255), 1'b1, 8'd200);
        send(pk(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 1'b1, 8'd21);
        send(pk(8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 1'b1, 8'd20);
        send(pk(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128), 1'b1, 8'd0);
        send(pk(8'd50, 8'd90, 8'd0, 8'd30, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0), 1'b0, 8'd0);
        drain();

        // Backpressure: 6 windows with a 4-cycle stall in the middle.
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                win_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                pix_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                pix_ready = 1'b1;
            end
        join
        drain();

        // Full frame plus one: pix_last on the 8th, 9th starts a new count.
        pulse_start();
        for (int i = 0; i < 9; i++) send_rand();
        drain();

        // Start after 3 outputs realigns the frame.
        for (int i = 0; i < 3; i++) send_rand();
        drain();
        pulse_start();
        for (int i = 0; i < 8; i++) send_rand();
        drain();

        // Random stream with random backpressure across several frames.
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) send_rand();
                win_valid   = 1'b0;
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    pix_ready = 1'($urandom_range(0, 1));
                end
                pix_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with a full pipeline.
        for (int i = 0; i < 4; i++) send_rand();
        win_valid = 1'b0;
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        #2;
        n_rst = 1'b1;
        #1;
        check("async_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("async_rst_frame_done", 32'(frame_done), 32'd0);
        check("async_rst_win_ready", 32'(win_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        latency_test("latency_after_rst");
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
